// File: rtl/counter_display_scan_pkg.sv
// Shared types and the hex-to-segment table for the multiplexed 7-segment display.
`timescale 1ns/100ps
package s4_display_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}, indexed by the hex digit value.
  localparam seg_t SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic seg_t hex2seg(input logic [3:0] nib);
    return SEG_LUT[nib];
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/counter_display_scan_hex_to_sevenseg.sv
// Combinational hex nibble to active-low seven-segment pattern.
`timescale 1ns/100ps
module hex_to_sevenseg
  import s4_display_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       segments
);

  assign segments = hex2seg(nibble);

endmodule

// File: rtl/counter_display_scan.sv
// Time-multiplexed hex display: frame snapshot of value, one active-low anode per slot,
// optional leading-zero blanking, registered anode/segment outputs.
`timescale 1ns/100ps
module counter_display_scan
  import s4_display_pkg::*;
#(
  parameter int N           = 32,
  parameter int DIGITS      = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N-1:0]      value,
  input  logic              blank_lz,
  output logic [DIGITS-1:0] anodes,
  output seg_t              segments,
  output logic              frame_done
);

  localparam int SW = 4 * DIGITS;
  localparam int PW = cnt_width(REFRESH_DIV);
  localparam int IW = cnt_width(DIGITS);
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  if (N > 4 * DIGITS) begin : g_bad_width
    $error("counter_display_scan: N (%0d) exceeds 4*DIGITS (%0d)", N, 4 * DIGITS);
  end
  if (DIGITS < 2) begin : g_bad_digits
    $error("counter_display_scan: DIGITS must be >= 2");
  end
  if (REFRESH_DIV < 1) begin : g_bad_div
    $error("counter_display_scan: REFRESH_DIV must be >= 1");
  end

  logic [PW-1:0]     prescaler;
  logic [IW-1:0]     idx;
  logic [SW-1:0]     shadow;
  logic              tick;
  logic              capture;
  logic [3:0]        nibble;
  logic              sel_blank;
  logic [DIGITS-1:0] anode_sel;
  logic [DIGITS-1:0] digit_blank;
  logic              nonzero_above;
  seg_t              seg_dec;

  assign tick    = (prescaler == PRESC_LAST);
  assign capture = tick && (idx == IDX_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
    end else if (tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx <= '0;
    end else if (tick) begin
      if (idx == IDX_LAST) begin
        idx <= '0;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  // The shadow is only refreshed as the last slot ends, so a whole frame shows one value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shadow     <= '0;
      frame_done <= 1'b0;
    end else begin
      if (capture) begin
        shadow <= SW'(value);
      end
      frame_done <= capture;
    end
  end

  // Digit i is a leading zero when it and every digit above it are zero.
  always_comb begin
    digit_blank   = '0;
    nonzero_above = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      nonzero_above  = nonzero_above | (|shadow[4*i +: 4]);
      digit_blank[i] = blank_lz & ~nonzero_above;
    end
  end

  always_comb begin
    nibble    = '0;
    sel_blank = 1'b0;
    anode_sel = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nibble       = shadow[4*i +: 4];
        sel_blank    = digit_blank[i];
        anode_sel[i] = 1'b0;
      end
    end
  end

  hex_to_sevenseg u_hex_to_sevenseg (
    .nibble   (nibble),
    .segments (seg_dec)
  );

  // Anodes and segments share one register stage so they always switch together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      anodes   <= '1;
      segments <= SEG_BLANK;
    end else if (sel_blank) begin
      anodes   <= '1;
      segments <= SEG_BLANK;
    end else begin
      anodes   <= anode_sel;
      segments <= seg_dec;
    end
  end

endmodule

// File: tb/tb_counter_display_scan.sv
// Directed bench for counter_display_scan with N=32, DIGITS=8, REFRESH_DIV=4.
`timescale 1ns/100ps
module tb_counter_display_scan;

  logic        clock;
  logic        reset;
  logic [31:0] value_drv;
  logic        blank_lz;
  logic [7:0]  anodes;
  logic [6:0]  segments;
  logic        frame_done;

  logic        use_cnt;
  logic        cnt_load;
  logic        cnt_en;
  logic [31:0] cnt_load_value;
  logic [31:0] cnt;
  logic [31:0] value;

  int checks = 0;
  int errors = 0;

  logic [6:0] lut [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  assign value = use_cnt ? cnt : value_drv;

  counter_display_scan #(
    .N           (32),
    .DIGITS      (8),
    .REFRESH_DIV (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .value      (value),
    .blank_lz   (blank_lz),
    .anodes     (anodes),
    .segments   (segments),
    .frame_done (frame_done)
  );

  initial clock = 1'b0;
  always #1 clock = ~clock;

  // Stand-in for the upstream up counter (load, enable, count up).
  always @(posedge clock) begin
    if (cnt_load) cnt <= cnt_load_value;
    else if (cnt_en) cnt <= cnt + 32'd1;
  end

  assert property (@(posedge clock) disable iff (reset) frame_done |=> !frame_done)
    else begin
      errors++;
      $error("FAIL fd_width observed=1 expected=0");
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic wait_fd(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (frame_done !== 1'b1 && n < 100);
    chk({tag, "_fd_seen"}, {31'd0, frame_done}, 32'd1);
  endtask

  function automatic logic slot_blank(input logic [31:0] v, input logic blz, input int j);
    return blz && (j > 0) && ((v >> (4 * j)) == 32'd0);
  endfunction

  function automatic logic [7:0] exp_an(input logic [31:0] v, input logic blz, input int j);
    logic [7:0] one;
    one = 8'd1 << j;
    return slot_blank(v, blz, j) ? 8'hFF : ~one;
  endfunction

  function automatic logic [6:0] exp_sg(input logic [31:0] v, input logic blz, input int j);
    return slot_blank(v, blz, j) ? 7'h7F : lut[v[4*j +: 4]];
  endfunction

  // Call on the frame_done sample; walks all eight slots of the following frame.
  task automatic check_frame(input string tag, input logic [31:0] v, input logic blz);
    @(negedge clock);
    for (int j = 0; j < 8; j++) begin
      if (j > 0) repeat (4) @(negedge clock);
      chk($sformatf("%s_an%0d", tag, j), {24'd0, anodes}, {24'd0, exp_an(v, blz, j)});
      chk($sformatf("%s_sg%0d", tag, j), {25'd0, segments}, {25'd0, exp_sg(v, blz, j)});
    end
  endtask

  initial begin
    reset          = 1'b1;
    value_drv      = 32'd0;
    blank_lz       = 1'b0;
    use_cnt        = 1'b0;
    cnt_load       = 1'b0;
    cnt_en         = 1'b0;
    cnt_load_value = 32'd0;

    // Reset state and first slot after release
    repeat (3) @(negedge clock);
    chk("rst_an", {24'd0, anodes}, 32'hFF);
    chk("rst_sg", {25'd0, segments}, 32'h7F);
    chk("rst_fd", {31'd0, frame_done}, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("rel_an", {24'd0, anodes}, 32'hFE);
    chk("rel_sg", {25'd0, segments}, 32'h40);

    // Asynchronous reset mid-frame while slot 5 is shown
    repeat (20) @(negedge clock);
    chk("slot5_an", {24'd0, anodes}, 32'hDF);
    #0.3 reset = 1'b1;
    #0.1;
    chk("arst_an", {24'd0, anodes}, 32'hFF);
    chk("arst_sg", {25'd0, segments}, 32'h7F);
    chk("arst_fd", {31'd0, frame_done}, 32'd0);
    repeat (3) @(negedge clock);
    chk("arst_hold_an", {24'd0, anodes}, 32'hFF);
    reset = 1'b0;
    @(negedge clock);
    chk("arel_an", {24'd0, anodes}, 32'hFE);
    chk("arel_sg", {25'd0, segments}, 32'h40);

    // 0xA5 without blanking: FE/12, FD/08, then 40 on every other anode
    value_drv = 32'h0000_00A5;
    wait_fd("a5");
    check_frame("a5", 32'h0000_00A5, 1'b0);

    // Same value with blanking, then zero
    blank_lz = 1'b1;
    wait_fd("a5lz");
    check_frame("a5lz", 32'h0000_00A5, 1'b1);
    value_drv = 32'd0;
    wait_fd("zero");
    check_frame("zero", 32'd0, 1'b1);

    // Snapshot: a mid-frame change must not reach the display until the next capture
    blank_lz  = 1'b0;
    value_drv = 32'h0000_0011;
    wait_fd("snap");
    @(negedge clock);
    chk("snap_sg0", {25'd0, segments}, 32'h79);
    value_drv = 32'h0000_00FF;
    repeat (4) @(negedge clock);
    chk("snap_an1", {24'd0, anodes}, 32'hFD);
    chk("snap_sg1", {25'd0, segments}, 32'h79);
    wait_fd("snap_next");
    check_frame("snap_next", 32'h0000_00FF, 1'b0);

    // Frame period 32 cycles, pulse width 1, anode rotation every 4 cycles
    value_drv = 32'h1234_5678;
    wait_fd("rot");
    for (int c = 1; c <= 32; c++) begin
      logic [7:0] one;
      @(negedge clock);
      one = 8'd1 << ((c - 1) / 4);
      chk($sformatf("rot_an_c%0d", c), {24'd0, anodes}, {24'd0, ~one});
      chk($sformatf("rot_fd_c%0d", c), {31'd0, frame_done}, (c == 32) ? 32'd1 : 32'd0);
    end
    @(negedge clock);
    chk("fd_width", {31'd0, frame_done}, 32'd0);

    // Counter integration: FFFFFFFF frame, then the wrapped small count 0x1E
    blank_lz       = 1'b1;
    cnt_load_value = 32'hFFFF_FFFF;
    cnt_load       = 1'b1;
    @(negedge clock);
    cnt_load = 1'b0;
    use_cnt  = 1'b1;
    wait_fd("cnt_ff");
    cnt_en = 1'b1;
    check_frame("cnt_ff", 32'hFFFF_FFFF, 1'b1);
    wait_fd("cnt_wrap");
    check_frame("cnt_wrap", 32'h0000_001E, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
